// File: rtl/loga_pkg.sv
// ============================================================================
// Module  : loga_pkg
// Purpose : Shared types and constants for the logic-analyser capture core.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package loga_pkg;

  localparam int TRIG_CODE_W = 4;

  typedef enum logic [TRIG_CODE_W-1:0] {
    TRIG_DC   = 4'd0,
    TRIG_LOW  = 4'd1,
    TRIG_HIGH = 4'd2,
    TRIG_RISE = 4'd3,
    TRIG_FALL = 4'd4,
    TRIG_ANY  = 4'd5
  } trig_code_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/loga_chan_trig.sv
// ============================================================================
// Module  : loga_chan_trig
// Purpose : Decodes one channel's trigger code against current/previous bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module loga_chan_trig
  import loga_pkg::*;
(
  input  logic [TRIG_CODE_W-1:0] i_code,
  input  logic                   i_cur,
  input  logic                   i_prev,
  input  logic                   i_prev_vld,
  output logic                   o_hit,
  output logic                   o_care
);

  // Unused codes 6..15 fall into the default arm and behave as don't-care.
  always_comb begin
    o_hit  = 1'b0;
    o_care = 1'b1;
    case (i_code)
      TRIG_LOW:  o_hit = ~i_cur;
      TRIG_HIGH: o_hit = i_cur;
      TRIG_RISE: o_hit = i_prev_vld & ~i_prev & i_cur;
      TRIG_FALL: o_hit = i_prev_vld & i_prev & ~i_cur;
      TRIG_ANY:  o_hit = i_prev_vld & (i_prev ^ i_cur);
      default:   o_care = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/loga_trig_capture.sv
// ============================================================================
// Module  : loga_trig_capture
// Purpose : Circular-buffer logic-analyser capture with pre-trigger and
//           oldest-first readout. Optional macro LOGA_DECIM_EN adds decimation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module loga_trig_capture
  import loga_pkg::*;
#(
  parameter int CHANNELS   = 8,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic [CHANNELS-1:0]       Data_IN,
  input  logic                      arm,
  input  logic                      abort,
  input  logic                      trig_mode,
  input  logic [4*CHANNELS-1:0]     trig_event,
  input  logic [DEPTH_LOG2-1:0]     pre_trig,
  input  logic                      rd_req,
`ifdef LOGA_DECIM_EN
  input  logic [7:0]                decim,
`endif
  output logic [CHANNELS-1:0]       Data_OUT,
  output logic                      rd_valid,
  output logic                      rd_last,
  output logic                      busy,
  output logic                      done,
  output logic [DEPTH_LOG2-1:0]     trig_addr
);

  localparam logic [DEPTH_LOG2-1:0] c_one = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0]   r_ram [0:(1<<DEPTH_LOG2)-1];
  state_e                r_state;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_pre;
  logic [DEPTH_LOG2-1:0] r_cnt;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_cnt;
  logic                  r_rd_end;
  logic [CHANNELS-1:0]   r_prev;
  logic                  r_prev_vld;

  logic                  w_active;
  logic                  w_take;
  logic                  w_write;
  logic                  w_arm_ok;
  logic                  w_fire;
  logic [CHANNELS-1:0]   w_hit;
  logic [CHANNELS-1:0]   w_care;

  assign w_active = (r_state == ST_ARMED) || (r_state == ST_WAIT_TRIG) ||
                    (r_state == ST_POST);
  assign w_arm_ok = arm && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_write  = w_active && w_take;
  assign busy     = w_active;
  assign done     = (r_state == ST_DONE);

`ifdef LOGA_DECIM_EN
  logic [7:0] r_div;

  // Divider phase 0 marks a taken sample; it restarts on every arm.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_div <= 8'd0;
    end else if (abort || w_arm_ok || !w_active) begin
      r_div <= 8'd0;
    end else begin
      r_div <= (r_div == decim) ? 8'd0 : r_div + 8'd1;
    end
  end

  assign w_take = (r_div == 8'd0);
`else
  assign w_take = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    loga_chan_trig u_chan_trig (
      .i_code     (trig_event[i*TRIG_CODE_W +: TRIG_CODE_W]),
      .i_cur      (Data_IN[i]),
      .i_prev     (r_prev[i]),
      .i_prev_vld (r_prev_vld),
      .o_hit      (w_hit[i]),
      .o_care     (w_care[i])
    );
  end

  // With every channel don't-care the AND reduction would be vacuously true.
  assign w_fire = (|w_care) &&
                  (trig_mode ? (&(w_hit | ~w_care)) : (|(w_hit & w_care)));

  always_ff @(posedge CLOCK) begin
    if (w_write) begin
      r_ram[r_wr_ptr] <= Data_IN;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_pre      <= '0;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_rd_end   <= 1'b0;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      trig_addr  <= '0;
      Data_OUT   <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
    end else if (abort) begin
      r_state   <= ST_IDLE;
      r_rd_ptr  <= '0;
      r_rd_cnt  <= '0;
      r_rd_end  <= 1'b0;
      trig_addr <= '0;
      Data_OUT  <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      if (w_write) begin
        r_wr_ptr   <= r_wr_ptr + c_one;
        r_prev     <= Data_IN;
        r_prev_vld <= 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_arm_ok) begin
            r_wr_ptr   <= '0;
            r_pre      <= pre_trig;
            r_cnt      <= '0;
            r_prev_vld <= 1'b0;
            r_state    <= (pre_trig == '0) ? ST_WAIT_TRIG : ST_ARMED;
          end else if (r_state == ST_DONE && rd_req && !r_rd_end) begin
            Data_OUT <= r_ram[r_rd_ptr];
            rd_valid <= 1'b1;
            rd_last  <= &r_rd_cnt;
            r_rd_end <= &r_rd_cnt;
            r_rd_ptr <= r_rd_ptr + c_one;
            r_rd_cnt <= r_rd_cnt + c_one;
          end
        end
        ST_ARMED: begin
          if (w_take) begin
            if (r_cnt == r_pre - c_one) begin
              r_cnt   <= '0;
              r_state <= ST_WAIT_TRIG;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        ST_WAIT_TRIG: begin
          if (w_take && w_fire) begin
            trig_addr <= r_wr_ptr;
            r_cnt     <= '0;
            // A full pre-trigger leaves no post samples to collect.
            if (&r_pre) begin
              r_state  <= ST_DONE;
              r_rd_ptr <= r_wr_ptr - r_pre;
              r_rd_cnt <= '0;
              r_rd_end <= 1'b0;
            end else begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          if (w_take) begin
            if (r_cnt == ~r_pre - c_one) begin
              r_state  <= ST_DONE;
              r_rd_ptr <= trig_addr - r_pre;
              r_rd_cnt <= '0;
              r_rd_end <= 1'b0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
